signed_divider: RTL and testbench

- Sequential signed divider. It is the inverse of the team's 8x8 signed shift-add multiplier.
- Takes a 16-bit two's-complement dividend, in the same {A,B} format the multiplier produces, and an 8-bit two's-complement divisor.
- Returns an 8-bit quotient and an 8-bit remainder.
- Sits beside the multiplier in the arithmetic datapath, driven by the same control-level run/done style.

---
 rtl/signed_divider_if.sv | 27 ++
 rtl/signed_divider.sv | 159 +++++++++++++++
 tb/tb_signed_divider.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/signed_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master side issues start with operands. The slave side (the divider)
// returns results, status flags and the busy/done handshake.
interface signed_divider_if #(
  parameter int N_DIVIDEND = 16,
  parameter int N_OPERAND  = 8
);
  logic                  start;
  logic [N_DIVIDEND-1:0] dividend;
  logic [N_OPERAND-1:0]  divisor;
  logic [N_OPERAND-1:0]  quotient;
  logic [N_OPERAND-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/signed_divider.sv
// Sequential signed divider: a 16-bit two's-complement dividend divided by an
// 8-bit two's-complement divisor, one restoring step per cycle.
// The operands are reduced to magnitudes on capture. The quotient magnitude
// shifts into the vacated low bits of the dividend register. Signs are
// reapplied in FIX: the quotient truncates toward zero, and the remainder
// takes the sign of the dividend.
// done pulses in the cycle after the edge that writes the results. On the
// normal path FIX writes them. On the divide-by-zero path FINISH writes them.
module signed_divider #(
  parameter int N_DIVIDEND = 16,
  parameter int N_OPERAND  = 8
) (
  input logic                clk,
  input logic                reset_n,
  signed_divider_if.slave    bus
);

  localparam int CNT_W = $clog2(N_DIVIDEND);
  localparam int REM_W = N_OPERAND + 1;

  // Largest quotient magnitudes that still fit the signed result
  localparam logic [N_DIVIDEND-1:0] Q_POS_MAX = N_DIVIDEND'((2 ** (N_OPERAND - 1)) - 1);
  localparam logic [N_DIVIDEND-1:0] Q_NEG_MAX = N_DIVIDEND'(2 ** (N_OPERAND - 1));

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIX,
    FINISH
  } state_e;

  state_e                 state_q;
  logic [N_DIVIDEND-1:0]  dvd_mag_q;   // dividend magnitude, becomes quotient magnitude
  logic [N_OPERAND-1:0]   dvs_mag_q;
  logic [REM_W-1:0]       prem_q;      // partial remainder
  logic [CNT_W-1:0]       count_q;
  logic                   q_neg_q;
  logic                   r_neg_q;
  logic                   zero_div_q;  // divide-by-zero path taken for this operation

  logic [N_OPERAND-1:0]   quotient_q;
  logic [N_OPERAND-1:0]   remainder_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   div_by_zero_q;
  logic                   overflow_q;

  // Combinational datapath signals
  logic [N_DIVIDEND-1:0]  dvd_mag_d;
  logic [N_OPERAND-1:0]   dvs_mag_d;
  logic [REM_W:0]         shifted_d;
  logic [REM_W:0]         trial_d;
  logic                   trial_ok_d;
  logic [N_OPERAND-1:0]   quotient_d;
  logic [N_OPERAND-1:0]   remainder_d;
  logic [N_OPERAND-1:0]   zdiv_rem_d;
  logic                   overflow_d;

  // Operand magnitudes, one restoring trial subtraction, and sign fix-up
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dvd_mag_d   = bus.dividend;
    dvs_mag_d   = bus.divisor;
    if (bus.dividend[N_DIVIDEND-1]) dvd_mag_d = -bus.dividend;
    if (bus.divisor[N_OPERAND-1])   dvs_mag_d = -bus.divisor;

    // Shift {partial_rem, dividend_mag} left by one and try the subtraction.
    // A borrow out of the extra top bit means the trial went negative.
    shifted_d   = {prem_q, dvd_mag_q[N_DIVIDEND-1]};
    trial_d     = shifted_d - {2'b00, dvs_mag_q};
    trial_ok_d  = ~trial_d[REM_W];

    // Only the low byte of the magnitude matters for the presented quotient
    quotient_d  = q_neg_q ? -dvd_mag_q[N_OPERAND-1:0] : dvd_mag_q[N_OPERAND-1:0];
    remainder_d = r_neg_q ? -prem_q[N_OPERAND-1:0] : prem_q[N_OPERAND-1:0];
    overflow_d  = q_neg_q ? (dvd_mag_q > Q_NEG_MAX) : (dvd_mag_q > Q_POS_MAX);

    // Low byte of the original dividend, rebuilt from its sign and magnitude
    zdiv_rem_d  = r_neg_q ? -dvd_mag_q[N_OPERAND-1:0] : dvd_mag_q[N_OPERAND-1:0];
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dvd_mag_q     <= '0;
      dvs_mag_q     <= '0;
      prem_q        <= '0;
      count_q       <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      zero_div_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every branch sees pre-edge values.
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            dvd_mag_q     <= dvd_mag_d;
            dvs_mag_q     <= dvs_mag_d;
            q_neg_q       <= bus.dividend[N_DIVIDEND-1] ^ bus.divisor[N_OPERAND-1];
            r_neg_q       <= bus.dividend[N_DIVIDEND-1];
            prem_q        <= '0;
            count_q       <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b1;
            zero_div_q    <= (bus.divisor == '0);
            state_q       <= (bus.divisor == '0) ? FINISH : DIVIDE;
          end
        end

        DIVIDE: begin
          dvd_mag_q <= {dvd_mag_q[N_DIVIDEND-2:0], trial_ok_d};
          prem_q    <= trial_ok_d ? trial_d[REM_W-1:0] : shifted_d[REM_W-1:0];
          count_q   <= count_q + 1'b1;
          if (count_q == CNT_W'(N_DIVIDEND - 1)) state_q <= FIX;
        end

        FIX: begin
          quotient_q  <= quotient_d;
          remainder_q <= remainder_d;
          overflow_q  <= overflow_d;
          done_q      <= 1'b1;
          state_q     <= FINISH;
        end

        FINISH: begin
          if (zero_div_q) begin
            quotient_q    <= '0;
            remainder_q   <= zdiv_rem_d;
            div_by_zero_q <= 1'b1;
            done_q        <= 1'b1;
          end else begin
            done_q        <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider. It applies directed corner cases and
// randomized operands. Expected results come from plain integer division.
module tb_signed_divider;

  localparam int N_DIVIDEND = 16;
  localparam int N_OPERAND  = 8;
  localparam int LAT_NORMAL = 17;  // edges after the accepting edge until done is seen
  localparam int LAT_ZERO   = 1;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  signed_divider_if #(.N_DIVIDEND(N_DIVIDEND), .N_OPERAND(N_OPERAND)) bus ();

  signed_divider #(.N_DIVIDEND(N_DIVIDEND), .N_OPERAND(N_OPERAND)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer division truncates toward zero and % follows the dividend sign
  function automatic void model(input logic [15:0] dvd, input logic [7:0] dvs,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z, output logic o);
    int a, b, qi, ri;
    a = int'($signed(dvd));
    b = int'($signed(dvs));
    if (b == 0) begin
      q = 8'h00;
      r = dvd[7:0];
      z = 1'b1;
      o = 1'b0;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[7:0];
      r  = ri[7:0];
      z  = 1'b0;
      o  = (qi > 127) || (qi < -128);
    end
  endfunction

  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs);
    logic [7:0] eq, er;
    logic       ez, eo, seen;
    int         n;
    model(dvd, dvs, eq, er, ez, eo);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.done;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), ez ? 32'(LAT_ZERO) : 32'(LAT_NORMAL));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    check("overflow", 32'(bus.overflow), 32'(eo));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dvd_ext [4];
    logic [7:0]  dvs_ext [4];
    logic [7:0]  eq, er;
    logic        ez, eo;
    int          dones;
    n_checks = 0;
    n_fail   = 0;
    dvd_ext  = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    dvs_ext  = '{8'h80, 8'h7F, 8'h01, 8'hFF};

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases, including the overflow boundaries and divide by zero
    run_op(16'd100, 8'd7);
    run_op(16'hFF9C, 8'd7);
    run_op(16'd300, 8'hFD);
    run_op(16'd16384, 8'h80);
    run_op(16'hC000, 8'h80);
    run_op(16'd1000, 8'd3);
    run_op(16'h1234, 8'h00);
    run_op(16'h8000, 8'hFF);
    run_op(16'h8000, 8'h80);

    // start while busy is ignored and produces exactly one done pulse
    model(16'd100, 8'd7, eq, er, ez, eo);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        check("busy_start_q", 32'(bus.quotient), 32'(eq));
        check("busy_start_r", 32'(bus.remainder), 32'(er));
      end
    end
    check("busy_start_dones", 32'(dones), 32'd1);

    // start held high runs back-to-back operations
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'hFF9C;
    bus.divisor  = 8'd7;
    model(16'hFF9C, 8'd7, eq, er, ez, eo);
    @(posedge clk);
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        check("held_start_q", 32'(bus.quotient), 32'(eq));
      end
    end
    check("held_start_dones", 32'(dones), 32'd2);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("held_start_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of DIVIDE
    run_op(16'd1000, 8'd3);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_q", 32'(bus.quotient), 32'd0);
    check("async_rst_r", 32'(bus.remainder), 32'd0);
    check("async_rst_ovf", 32'(bus.overflow), 32'd0);
    check("async_rst_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op(16'd100, 8'd7);

    // Randomized operands
    for (int k = 0; k < 40; k++) begin
      logic [15:0] dvd;
      logic [7:0]  dvs;
      case ($urandom_range(0, 3))
        0: begin
          dvd = 16'($urandom);
          dvs = 8'($urandom);
        end
        1: begin
          dvd = 16'($urandom_range(0, 2000)) - 16'd1000;
          dvs = 8'($urandom);
        end
        2: begin
          dvd = 16'($urandom);
          dvs = 8'h00;
        end
        default: begin
          dvd = dvd_ext[$urandom_range(0, 3)];
          dvs = dvs_ext[$urandom_range(0, 3)];
        end
      endcase
      run_op(dvd, dvs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
